// File: rtl/fetch_arbiter_pkg.sv
// Shared types for the instruction-fetch arbiter and related memory-port arbiters.
package fetch_arbiter_pkg;

    localparam int NUM_WARPS_DEFAULT = 4;

    typedef logic [31:0] instruction_t;
    typedef logic [15:0] instruction_memory_address_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_MEM_WAIT,
        ARB_RESPOND
    } arbiter_state_t;

endpackage

// File: rtl/fetch_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo N (so non-power-of-two N never selects a phantom slot).
module fetch_arbiter_rr_priority_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_request,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_winner
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_found    = 1'b0;
        o_winner   = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_cand = int'(i_rr_ptr) + off;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (i_request[w_cand_idx]) begin
                o_found  = 1'b1;
                o_winner = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one instruction-memory read port among NUM_WARPS fetchers, one
// outstanding read at a time, round-robin order advancing on completion.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter  int NUM_WARPS = NUM_WARPS_DEFAULT,
    localparam int IDX_W     = $clog2(NUM_WARPS)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [NUM_WARPS-1:0]                        i_req_valid,
    input  instruction_memory_address_t [NUM_WARPS-1:0] i_req_address,
    output logic [NUM_WARPS-1:0]                        o_req_ready,
    output instruction_t                                o_req_data,
    output logic                                        o_mem_read_valid,
    output instruction_memory_address_t                 o_mem_read_address,
    input  logic                                        i_mem_read_ready,
    input  instruction_t                                i_mem_read_data,
    output logic                                        o_busy,
    output logic [IDX_W-1:0]                            o_grant_id
);

    arbiter_state_t              r_state,     w_state;
    logic [IDX_W-1:0]            r_rr_ptr,    w_rr_ptr;
    logic [IDX_W-1:0]            r_grant_id,  w_grant_id;
    logic [NUM_WARPS-1:0]        r_req_ready, w_req_ready;
    instruction_t                r_req_data,  w_req_data;
    logic                        r_mem_valid, w_mem_valid;
    instruction_memory_address_t r_mem_addr,  w_mem_addr;

    logic             w_found;
    logic [IDX_W-1:0] w_winner;

    fetch_arbiter_rr_priority_picker #(
        .N (NUM_WARPS)
    ) u_picker (
        .i_request (i_req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_found   (w_found),
        .o_winner  (w_winner)
    );

    // The RESPOND state never grants, so a served fetcher's valid drop lands first.
    always_comb begin
        w_state     = r_state;
        w_rr_ptr    = r_rr_ptr;
        w_grant_id  = r_grant_id;
        w_req_ready = '0;
        w_req_data  = r_req_data;
        w_mem_valid = r_mem_valid;
        w_mem_addr  = r_mem_addr;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_grant_id  = w_winner;
                    w_mem_addr  = i_req_address[w_winner];
                    w_mem_valid = 1'b1;
                    w_state     = ARB_MEM_WAIT;
                end
            end
            ARB_MEM_WAIT: begin
                if (i_mem_read_ready) begin
                    w_req_data              = i_mem_read_data;
                    w_req_ready[r_grant_id] = 1'b1;
                    w_mem_valid             = 1'b0;
                    w_rr_ptr                = (r_grant_id == IDX_W'(NUM_WARPS - 1))
                                              ? '0 : r_grant_id + IDX_W'(1);
                    w_state                 = ARB_RESPOND;
                end
            end
            ARB_RESPOND: begin
                w_state = ARB_IDLE;
            end
            default: begin
                w_state = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_req_ready <= '0;
            r_req_data  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_state     <= w_state;
            r_rr_ptr    <= w_rr_ptr;
            r_grant_id  <= w_grant_id;
            r_req_ready <= w_req_ready;
            r_req_data  <= w_req_data;
            r_mem_valid <= w_mem_valid;
            r_mem_addr  <= w_mem_addr;
        end
    end

    assign o_req_ready        = r_req_ready;
    assign o_req_data         = r_req_data;
    assign o_mem_read_valid   = r_mem_valid;
    assign o_mem_read_address = r_mem_addr;
    assign o_grant_id         = r_grant_id;
    assign o_busy             = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_fetch_arbiter.sv
// Randomized fetchers and memory around fetch_arbiter, checked against a
// transaction-level round-robin model with a response scoreboard.
module tb_fetch_arbiter;
    import fetch_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = $clog2(N);
    localparam int CYCLES_PER_PHASE = 600;

    logic                                i_clk = 1'b0;
    logic                                i_rst = 1'b1;
    logic [N-1:0]                        i_req_valid = '0;
    instruction_memory_address_t [N-1:0] i_req_address = '0;
    logic [N-1:0]                        o_req_ready;
    instruction_t                        o_req_data;
    logic                                o_mem_read_valid;
    instruction_memory_address_t         o_mem_read_address;
    logic                                i_mem_read_ready = 1'b0;
    instruction_t                        i_mem_read_data = '0;
    logic                                o_busy;
    logic [IDX_W-1:0]                    o_grant_id;

    fetch_arbiter #(
        .NUM_WARPS (N)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .i_req_address      (i_req_address),
        .o_req_ready        (o_req_ready),
        .o_req_data         (o_req_data),
        .o_mem_read_valid   (o_mem_read_valid),
        .o_mem_read_address (o_mem_read_address),
        .i_mem_read_ready   (i_mem_read_ready),
        .i_mem_read_data    (i_mem_read_data),
        .o_busy             (o_busy),
        .o_grant_id         (o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int           warp;
        instruction_t data;
    } expect_t;

    expect_t scoreboard[$];
    int      checksTotal  = 0;
    int      checksPassed = 0;
    int      completions  = 0;

    bit                          pending[N];
    instruction_memory_address_t fetchAddr[N];
    int                          reqRate;
    int                          memRate;
    int                          holdReset;
    bit                          resetDone;

    bit                          txnOpen;
    bit                          cooldown;
    int                          modelPtr;
    int                          curWinner;
    instruction_memory_address_t expAddr;

    function automatic instruction_t memFunc(input instruction_memory_address_t a);
        return ({16'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic int pickWinner(input logic [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkResetState();
        checkOutput("reset_mem_read_valid", o_mem_read_valid, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_req_ready", o_req_ready, 0);
        checkOutput("reset_grant_id", o_grant_id, 0);
        checkOutput("reset_req_data", o_req_data, 0);
        checkOutput("reset_mem_read_address", o_mem_read_address, 0);
    endtask

    task automatic modelReset();
        txnOpen   = 0;
        cooldown  = 0;
        modelPtr  = 0;
        curWinner = 0;
        scoreboard.delete();
    endtask

    // Fetchers hold valid until their ready pulse; memory answers at random.
    task automatic applyStimulus();
        if (holdReset > 0) begin
            holdReset--;
            for (int w = 0; w < N; w++) begin
                pending[w] = (holdReset == 0);
                if (holdReset == 0) fetchAddr[w] = instruction_memory_address_t'($urandom);
            end
            if (holdReset == 0) i_rst = 1'b0;
        end else begin
            for (int w = 0; w < N; w++) begin
                if (o_req_ready[w]) begin
                    pending[w] = 0;
                end else if (!pending[w] && $urandom_range(0, 99) < reqRate) begin
                    pending[w]   = 1;
                    fetchAddr[w] = instruction_memory_address_t'($urandom);
                end
            end
            if (txnOpen && $urandom_range(0, 3) == 0)
                fetchAddr[curWinner] = instruction_memory_address_t'($urandom);
        end
        for (int w = 0; w < N; w++) begin
            i_req_valid[w]   = pending[w];
            i_req_address[w] = fetchAddr[w];
        end
        i_mem_read_ready = ($urandom_range(0, 99) < memRate);
        i_mem_read_data  = o_mem_read_valid ? memFunc(o_mem_read_address)
                                            : instruction_t'($urandom);
    endtask

    // One transaction at a time: grant, wait for memory, one respond cycle.
    task automatic modelStep();
        int winner;
        if (cooldown) begin
            cooldown = 0;
        end else if (!txnOpen) begin
            winner = pickWinner(i_req_valid, modelPtr);
            if (winner >= 0) begin
                expect_t e;
                txnOpen   = 1;
                curWinner = winner;
                expAddr   = i_req_address[winner];
                e.warp    = winner;
                e.data    = memFunc(expAddr);
                scoreboard.push_back(e);
            end
        end else if (i_mem_read_ready) begin
            txnOpen  = 0;
            cooldown = 1;
            modelPtr = (curWinner + 1) % N;
        end
        checkOutput("mem_read_valid", o_mem_read_valid, txnOpen);
        checkOutput("busy", o_busy, txnOpen || cooldown);
        checkOutput("grant_id", o_grant_id, curWinner);
        checkOutput("req_ready_timing", |o_req_ready, cooldown);
        if (txnOpen) checkOutput("mem_read_address", o_mem_read_address, expAddr);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_rst && o_req_ready != '0) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_req_ready", o_req_ready, 0);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("req_ready_onehot", o_req_ready, 64'(1) << e.warp);
                    checkOutput("req_data", o_req_data, e.data);
                    completions++;
                end
            end
        end
    end

    initial begin
        int rates[3][2];
        rates     = '{'{100, 100}, '{40, 30}, '{80, 15}};
        holdReset = 3;
        resetDone = 0;
        for (int w = 0; w < N; w++) begin
            pending[w]   = 0;
            fetchAddr[w] = '0;
        end
        modelReset();
        @(posedge i_clk);
        #1;
        checkResetState();
        for (int phase = 0; phase < 3; phase++) begin
            reqRate = rates[phase][0];
            memRate = rates[phase][1];
            for (int cyc = 0; cyc < CYCLES_PER_PHASE; cyc++) begin
                @(negedge i_clk);
                applyStimulus();
                @(posedge i_clk);
                #1;
                if (i_rst) checkResetState();
                else modelStep();
                if (phase == 1 && cyc >= 200 && !resetDone && txnOpen) begin
                    #2;
                    i_rst = 1'b1;
                    #1;
                    checkResetState();
                    modelReset();
                    holdReset = 2;
                    resetDone = 1;
                end
            end
        end
        checkOutput("mid_reset_exercised", resetDone, 1);
        checkOutput("enough_completions", completions > 100, 1);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
